one_b: RTL and testbench
========================

ONE_B -- requirements
Module: one_b

Interface
REQ-001 Parameter CNT_W, default 8, width of the saturating hit counter (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  1  function variable A (MSB of the minterm index).
REQ-005 b  input  1  function variable B.
REQ-006 c  input  1  function variable C.
REQ-007 d  input  1  function variable D (LSB of the minterm index).
REQ-008 en  input  1  capture enable for the registered stage.
REQ-009 f_comb  output  1  combinational function value of the current a,b,c,d.
REQ-010 f  output  1  registered function value.
REQ-011 minterm  output  16  registered one-hot decode of the captured index.
REQ-012 hit_cnt  output  CNT_W  saturating count of captures with function value 1.
REQ-013 hit_sat  output  1  high while hit_cnt equals its all-ones maximum.

Function
REQ-014 Index idx = {a,b,c,d}, with a as the MSB (0..15).
REQ-015 The function is F = sum of minterms (1,3,4,5,9,11,14,15), i.e. truth-table constant 16'hCA3A indexed by idx.
REQ-016 F in minimized form is B'D + A'BC' + ABC; the implementation and the truth-table constant must agree for all 16 indices.
REQ-017 f_comb equals F(idx) combinationally, with no clock dependence and no latch.
REQ-018 On each rising clk edge with en=1: f <= F(idx); minterm <= one-hot with only bit idx set.
REQ-019 On each rising clk edge with en=0: f and minterm hold their values.
REQ-020 Latency: f and minterm reflect the inputs sampled at the enabling edge, visible one cycle after the edge.
REQ-021 On each enabled edge where F(idx)=1, hit_cnt increments by 1, unless it is already all-ones, in which case it holds (no wrap).
REQ-022 When en=0 or F(idx)=0, hit_cnt holds.
REQ-023 hit_sat is combinational from hit_cnt: it is 1 iff hit_cnt equals 2^CNT_W-1.
REQ-024 X or Z on a..d is not required to be handled; behaviour for those values is unspecified.

Reset
REQ-025 When rst_n=0: f=0, minterm=16'h0000, hit_cnt=0, hit_sat=0, applied immediately without waiting for clk.
REQ-026 f_comb is unaffected by reset.
REQ-027 Reset asserted mid-count clears hit_cnt; the count restarts from 0 after release.
REQ-028 The first enabled edge after reset release captures normally.

Structure
REQ-029 A shared package one_b_pkg holds the following constants:
- TRUTH_TABLE = 16'hCA3A
- IDX_W = 4
REQ-030 One sub-module, one_b_func, is the pure combinational evaluator: 4 inputs, 1 output, used for f_comb and for the registered path.
REQ-031 All sequential logic resides in one_b in a single clocked process that is sensitive to the clk rising edge and the rst_n falling edge.

Verification
REQ-032 Exhaustive sweep: idx 0..15 in order with en=1, one per cycle -> f_comb and f sequence 0,1,0,1,1,1,0,0,0,1,0,1,0,0,1,1 (f one cycle later), with minterm[idx]=1 only.
REQ-033 Counter check: after the full sweep from reset -> hit_cnt=8, hit_sat=0.
REQ-034 Hold check: capture idx=5, then en=0 and drive idx=0 for 3 cycles:
- f stays 1.
- minterm stays 16'h0020.
- hit_cnt is unchanged.
- f_comb=0.
REQ-035 Saturation with CNT_W=2: drive idx=15 with en=1 for 5 cycles -> hit_cnt goes 1,2,3,3,3; hit_sat=1 from the third capture onward.
REQ-036 Async reset: assert rst_n=0 between clock edges while f=1 and hit_cnt=3 -> all registered outputs are 0 before the next edge; after release, the count restarts from 0.

Source files
------------

// File: rtl/one_b_pkg.sv
// Shared constants and helpers for the one_b four-variable function block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package one_b_pkg;

    // Truth table of F indexed by {a,b,c,d}; minterms 1,3,4,5,9,11,14,15.
    localparam logic [15:0] TRUTH_TABLE = 16'hCA3A;

    // Width of the minterm index {a,b,c,d}.
    localparam int IDX_W = 4;

    // One-hot decode of a minterm index.
    function automatic logic [(1 << IDX_W)-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [(1 << IDX_W)-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage : one_b_pkg

// File: rtl/one_b_func.sv
// Combinational evaluator of F = B'D + A'BC' + ABC.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   a, b, c, d : function variables (a is the MSB of the minterm index)
//   f          : F(a,b,c,d)
module one_b_func
    import one_b_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f
);

    // Minimized sum-of-products; equivalent to TRUTH_TABLE[{a,b,c,d}].
    always_comb begin
        f = (~b & d) | (~a & b & ~c) | (a & b & c);
    end

endmodule : one_b_func

// File: rtl/one_b.sv
// Four-variable function block: combinational F, registered F/one-hot index, saturating hit counter.
// Latency: f_comb 0 cycles; f, minterm, hit_cnt update on the enabled rising edge.
// Backpressure: none; en=0 simply holds all registered state.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   a, b, c, d   : function variables, idx = {a,b,c,d}
//   en           : capture enable for the registered stage
//   f_comb       : F(idx), combinational, unaffected by reset
//   f            : registered F
//   minterm      : registered one-hot decode of the captured idx
//   hit_cnt      : saturating count of captures where F was 1
//   hit_sat      : high while hit_cnt is all-ones
module one_b
    import one_b_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             en,
    output logic             f_comb,
    output logic             f,
    output logic [15:0]      minterm,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             hit_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [IDX_W-1:0] idx;
    logic             func_val;

    logic             f_d,       f_q;
    logic [15:0]      minterm_d, minterm_q;
    logic [CNT_W-1:0] hit_cnt_d, hit_cnt_q;

    assign idx = {a, b, c, d};

    // Single evaluator feeds both the combinational output and the capture path.
    one_b_func u_func (
        .a (a),
        .b (b),
        .c (c),
        .d (d),
        .f (func_val)
    );

    always_comb begin
        f_d       = f_q;
        minterm_d = minterm_q;
        hit_cnt_d = hit_cnt_q;
        if (en) begin
            f_d       = func_val;
            minterm_d = idx_onehot(idx);
            // Saturate rather than wrap once the counter is full.
            if (func_val && (hit_cnt_q != CNT_MAX)) begin
                hit_cnt_d = hit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q       <= 1'b0;
            minterm_q <= 16'h0000;
            hit_cnt_q <= '0;
        end else begin
            f_q       <= f_d;
            minterm_q <= minterm_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign f_comb  = func_val;
    assign f       = f_q;
    assign minterm = minterm_q;
    assign hit_cnt = hit_cnt_q;
    assign hit_sat = (hit_cnt_q == CNT_MAX);

endmodule : one_b

// File: tb/tb_one_b.sv
// Self-checking bench for one_b: exhaustive sweep, hold, saturation (CNT_W=2), async reset.
// Latency: checks registered outputs #1 after the capturing rising edge.
// Backpressure: n/a.
module tb_one_b;

    logic        clk;
    logic        rst_n;
    logic        a, b, c, d, en;

    logic        f_comb8, f8, sat8;
    logic [15:0] mt8;
    logic [7:0]  cnt8;

    logic        f_comb2, f2, sat2;
    logic [15:0] mt2;
    logic [1:0]  cnt2;

    int n_checks;
    int n_fail;

    one_b #(.CNT_W(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .en      (en),
        .f_comb  (f_comb8),
        .f       (f8),
        .minterm (mt8),
        .hit_cnt (cnt8),
        .hit_sat (sat8)
    );

    one_b #(.CNT_W(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .en      (en),
        .f_comb  (f_comb2),
        .f       (f2),
        .minterm (mt2),
        .hit_cnt (cnt2),
        .hit_sat (sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic        f_exp;
        logic [15:0] mt_exp;
    } vec_t;

    typedef struct {
        logic [1:0] cnt_exp;
        logic       sat_exp;
    } sat_vec_t;

    vec_t     sweep [16];
    sat_vec_t satv  [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] idx, input logic e);
        {a, b, c, d} = idx;
        en           = e;
    endtask

    initial begin
        logic [15:0] tt;
        int          model_cnt;

        n_checks = 0;
        n_fail   = 0;
        tt       = 16'hCA3A;

        // Hand-computed sweep: F = 0,1,0,1,1,1,0,0,0,1,0,1,0,0,1,1
        sweep[0]  = '{4'd0,  1'b0, 16'h0001};
        sweep[1]  = '{4'd1,  1'b1, 16'h0002};
        sweep[2]  = '{4'd2,  1'b0, 16'h0004};
        sweep[3]  = '{4'd3,  1'b1, 16'h0008};
        sweep[4]  = '{4'd4,  1'b1, 16'h0010};
        sweep[5]  = '{4'd5,  1'b1, 16'h0020};
        sweep[6]  = '{4'd6,  1'b0, 16'h0040};
        sweep[7]  = '{4'd7,  1'b0, 16'h0080};
        sweep[8]  = '{4'd8,  1'b0, 16'h0100};
        sweep[9]  = '{4'd9,  1'b1, 16'h0200};
        sweep[10] = '{4'd10, 1'b0, 16'h0400};
        sweep[11] = '{4'd11, 1'b1, 16'h0800};
        sweep[12] = '{4'd12, 1'b0, 16'h1000};
        sweep[13] = '{4'd13, 1'b0, 16'h2000};
        sweep[14] = '{4'd14, 1'b1, 16'h4000};
        sweep[15] = '{4'd15, 1'b1, 16'h8000};

        satv[0] = '{2'd1, 1'b0};
        satv[1] = '{2'd2, 1'b0};
        satv[2] = '{2'd3, 1'b1};
        satv[3] = '{2'd3, 1'b1};
        satv[4] = '{2'd3, 1'b1};

        // Reset state, checked before any clock edge.
        rst_n = 1'b0;
        drive(4'd0, 1'b0);
        #3;
        chk("rst_f",       {31'd0, f8},   32'd0);
        chk("rst_minterm", {16'd0, mt8},  32'd0);
        chk("rst_hit_cnt", {24'd0, cnt8}, 32'd0);
        chk("rst_hit_sat", {31'd0, sat8}, 32'd0);
        chk("rst_cnt2",    {30'd0, cnt2}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive sweep, one index per cycle.
        model_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(sweep[i].idx, 1'b1);
            #1;
            chk($sformatf("sweep_f_comb[%0d]", i), {31'd0, f_comb8}, {31'd0, sweep[i].f_exp});
            chk($sformatf("sweep_tt[%0d]", i), {31'd0, f_comb8}, {31'd0, tt[sweep[i].idx]});
            @(posedge clk);
            #1;
            if (sweep[i].f_exp) model_cnt++;
            chk($sformatf("sweep_f[%0d]", i),       {31'd0, f8},  {31'd0, sweep[i].f_exp});
            chk($sformatf("sweep_minterm[%0d]", i), {16'd0, mt8}, {16'd0, sweep[i].mt_exp});
            chk($sformatf("sweep_cnt[%0d]", i),     {24'd0, cnt8}, model_cnt);
        end
        chk("sweep_final_cnt", {24'd0, cnt8}, 32'd8);
        chk("sweep_final_sat", {31'd0, sat8}, 32'd0);

        // Hold: capture idx=5, then en=0 with idx=0 for three cycles.
        @(negedge clk);
        drive(4'd5, 1'b1);
        @(posedge clk);
        #1;
        chk("hold_cap_f",       {31'd0, f8},  32'd1);
        chk("hold_cap_minterm", {16'd0, mt8}, 32'h0020);
        chk("hold_cap_cnt",     {24'd0, cnt8}, 32'd9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(4'd0, 1'b0);
            #1;
            chk($sformatf("hold_f_comb[%0d]", k), {31'd0, f_comb8}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("hold_f[%0d]", k),       {31'd0, f8},   32'd1);
            chk($sformatf("hold_minterm[%0d]", k), {16'd0, mt8},  32'h0020);
            chk($sformatf("hold_cnt[%0d]", k),     {24'd0, cnt8}, 32'd9);
        end

        // Saturation on the CNT_W=2 instance.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(4'd15, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("sat_cnt[%0d]", k), {30'd0, cnt2}, {30'd0, satv[k].cnt_exp});
            chk($sformatf("sat_flag[%0d]", k), {31'd0, sat2}, {31'd0, satv[k].sat_exp});
        end

        // Async reset mid-count: bring dut2 to f=1, hit_cnt=3, then reset between edges.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(4'd15, 1'b1);
            @(posedge clk);
        end
        #1;
        chk("arst_pre_f",   {31'd0, f2},   32'd1);
        chk("arst_pre_cnt", {30'd0, cnt2}, 32'd3);
        @(negedge clk);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_f",       {31'd0, f2},      32'd0);
        chk("arst_minterm", {16'd0, mt2},     32'd0);
        chk("arst_cnt",     {30'd0, cnt2},    32'd0);
        chk("arst_sat",     {31'd0, sat2},    32'd0);
        chk("arst_cnt8",    {24'd0, cnt8},    32'd0);
        chk("arst_f_comb",  {31'd0, f_comb2}, 32'd1);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        drive(4'd1, 1'b1);
        @(posedge clk);
        #1;
        chk("post_rst_f",       {31'd0, f2},   32'd1);
        chk("post_rst_minterm", {16'd0, mt2},  32'h0002);
        chk("post_rst_cnt",     {30'd0, cnt2}, 32'd1);
        chk("post_rst_sat",     {31'd0, sat2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_one_b
